// File: rtl/writeback_arbiter_if.sv
// Producer-side and writeback-side signal bundle for writeback_arbiter.
// slave = the arbiter; master = producers/ROB environment driving it.
interface writeback_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int NUM_WB = 2,
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*PREG_W-1:0] in_preg;
    logic [NUM_CH*ROB_W-1:0]  in_rob;
    logic [NUM_CH-1:0]        in_regwrite;

    logic [NUM_WB-1:0]        out_valid;
    logic [NUM_WB*DATA_W-1:0] out_data;
    logic [NUM_WB*PREG_W-1:0] out_preg;
    logic [NUM_WB*ROB_W-1:0]  out_rob;
    logic [NUM_WB-1:0]        out_regwrite;

    modport master (
        output in_valid, in_data, in_preg, in_rob, in_regwrite,
        input  in_ready,
        input  out_valid, out_data, out_preg, out_rob, out_regwrite
    );

    modport slave (
        input  in_valid, in_data, in_preg, in_rob, in_regwrite,
        output in_ready,
        output out_valid, out_data, out_preg, out_rob, out_regwrite
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-channel completion FIFOs drained round-robin onto NUM_WB registered writeback lanes.
// Latency: accept at edge N -> out_valid at edge N+1; in_ready is count-based, wb_stall freezes lanes.
// Optional WB_ARB_PERF_EN adds perf_bp_cycles (cycles with a producer blocked by a full FIFO).
module writeback_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int NUM_WB     = 2,
    parameter int DATA_W     = 32,
    parameter int PREG_W     = 6,
    parameter int ROB_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  wb_stall,
    writeback_arbiter_if.slave    wb_bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]           perf_bp_cycles
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int LN_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [PREG_W-1:0] preg;
        logic [ROB_W-1:0]  rob;
        logic              regwrite;
    } wb_entry_t;

    wb_entry_t         r_mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
    logic [PTR_W:0]    r_count  [NUM_CH];
    logic [CH_W-1:0]   r_rr_ptr;
    logic [NUM_WB-1:0] r_out_vld;
    wb_entry_t         r_out_ent [NUM_WB];

    wb_entry_t         w_in_ent   [NUM_CH];
    logic [NUM_CH-1:0] w_ready;
    logic [NUM_CH-1:0] w_enq;
    logic [NUM_CH-1:0] w_deq;
    logic [CH_W-1:0]   w_rr_nxt;
    logic [NUM_WB-1:0] w_lane_vld;
    wb_entry_t         w_lane_ent [NUM_WB];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_in_ent[c].dat      = wb_bus.in_data[c*DATA_W +: DATA_W];
        assign w_in_ent[c].preg     = wb_bus.in_preg[c*PREG_W +: PREG_W];
        assign w_in_ent[c].rob      = wb_bus.in_rob[c*ROB_W +: ROB_W];
        assign w_in_ent[c].regwrite = wb_bus.in_regwrite[c];
        assign w_ready[c]           = (r_count[c] < (PTR_W+1)'(FIFO_DEPTH));
        assign w_enq[c]             = wb_bus.in_valid[c] & w_ready[c] & ~flush;
    end

    assign wb_bus.in_ready = w_ready;

    // Scan from r_rr_ptr; the k-th non-empty channel found fills lane k.
    always_comb begin : p_grant
        int              n;
        logic [CH_W-1:0] ch;
        n          = 0;
        ch         = '0;
        w_deq      = '0;
        w_lane_vld = '0;
        w_rr_nxt   = r_rr_ptr;
        for (int l = 0; l < NUM_WB; l++) begin
            w_lane_ent[l] = '0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            ch = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
            if (!wb_stall && !flush && (r_count[ch] != '0) && (n < NUM_WB)) begin
                w_deq[ch]                = 1'b1;
                w_lane_vld[LN_W'(n)]     = 1'b1;
                w_lane_ent[LN_W'(n)]     = r_mem[ch][r_rd_ptr[ch]];
                w_rr_nxt                 = CH_W'((int'(ch) + 1) % NUM_CH);
                n                        = n + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
            r_rr_ptr <= '0;
        end else if (flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
            r_rr_ptr <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_enq[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
                if (w_deq[c]) r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
                if (w_enq[c] && !w_deq[c])      r_count[c] <= r_count[c] + (PTR_W+1)'(1);
                else if (!w_enq[c] && w_deq[c]) r_count[c] <= r_count[c] - (PTR_W+1)'(1);
            end
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Storage has no reset: occupancy is governed entirely by the counters.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_enq[c]) r_mem[c][r_wr_ptr[c]] <= w_in_ent[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vld <= '0;
            for (int l = 0; l < NUM_WB; l++) r_out_ent[l] <= '0;
        end else if (flush) begin
            r_out_vld <= '0;
            for (int l = 0; l < NUM_WB; l++) r_out_ent[l] <= '0;
        end else if (!wb_stall) begin
            r_out_vld <= w_lane_vld;
            for (int l = 0; l < NUM_WB; l++) r_out_ent[l] <= w_lane_ent[l];
        end
    end

    for (genvar l = 0; l < NUM_WB; l++) begin : g_lane
        assign wb_bus.out_data[l*DATA_W +: DATA_W] = r_out_ent[l].dat;
        assign wb_bus.out_preg[l*PREG_W +: PREG_W] = r_out_ent[l].preg;
        assign wb_bus.out_rob[l*ROB_W +: ROB_W]    = r_out_ent[l].rob;
        assign wb_bus.out_regwrite[l]              = r_out_ent[l].regwrite;
    end
    assign wb_bus.out_valid = r_out_vld;

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_perf_bp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_bp <= '0;
        end else if (flush) begin
            r_perf_bp <= '0;
        end else if (|(wb_bus.in_valid & ~w_ready) && (r_perf_bp != 32'hFFFF_FFFF)) begin
            r_perf_bp <= r_perf_bp + 32'd1;
        end
    end

    assign perf_bp_cycles = r_perf_bp;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (NUM_CH=4, NUM_WB=2, FIFO_DEPTH=4).
module tb_writeback_arbiter;
    localparam int NUM_CH = 4;
    localparam int NUM_WB = 2;
    localparam int DATA_W = 32;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic wb_stall;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.NUM_CH(NUM_CH), .NUM_WB(NUM_WB), .DATA_W(DATA_W),
                           .PREG_W(PREG_W), .ROB_W(ROB_W)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_bp_cycles;
`endif

    writeback_arbiter #(.NUM_CH(NUM_CH), .NUM_WB(NUM_WB), .DATA_W(DATA_W),
                        .PREG_W(PREG_W), .ROB_W(ROB_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .wb_stall (wb_stall),
        .wb_bus   (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_bp_cycles (perf_bp_cycles)
`endif
    );

    function automatic logic [31:0] lane_dat(input int l);
        return bus.out_data[l*DATA_W +: DATA_W];
    endfunction

    function automatic logic [5:0] lane_preg(input int l);
        return bus.out_preg[l*PREG_W +: PREG_W];
    endfunction

    task automatic set_ch(input int c, input logic [31:0] d, input logic [5:0] p,
                          input logic [5:0] r, input logic rw);
        bus.in_data[c*DATA_W +: DATA_W] = d;
        bus.in_preg[c*PREG_W +: PREG_W] = p;
        bus.in_rob[c*ROB_W +: ROB_W]    = r;
        bus.in_regwrite[c]              = rw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        flush = 1'b0;
        wb_stall = 1'b0;
        bus.in_valid = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        // traffic on ch0/ch1, then reset while lanes are busy
        set_ch(0, 32'hAAAA_0000, 6'd1, 6'd1, 1'b1);
        set_ch(1, 32'hBBBB_0000, 6'd2, 6'd2, 1'b1);
        bus.in_valid = 4'b0011;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 2'b11) $display("FAIL pre_reset_traffic: got %b want 11", bus.out_valid);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 2'b00) $display("FAIL rst_out_valid: got %b want 00", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 4'hF) $display("FAIL rst_in_ready: got %h want f", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_data !== 64'h0) $display("FAIL rst_out_data: got %h want 0", bus.out_data);
        else n_pass++;
        @(negedge clk);
        bus.in_valid = '0;
        reset_n = 1'b1;
        @(negedge clk);
        set_ch(2, 32'h0000_1234, 6'd9, 6'd3, 1'b1);
        bus.in_valid = 4'b0100;
        @(negedge clk);
        bus.in_valid = '0;
        n_checks++;
        if (bus.out_valid !== 2'b00) $display("FAIL rst_no_drain: got %b want 00", bus.out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 2'b01) $display("FAIL rst_ch2_vld: got %b want 01", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (lane_dat(0) !== 32'h1234) $display("FAIL rst_ch2_data: got %h want 00001234", lane_dat(0));
        else n_pass++;
        n_checks++;
        if (lane_preg(0) !== 6'd9) $display("FAIL rst_ch2_preg: got %0d want 9", lane_preg(0));
        else n_pass++;
        n_checks++;
        if (bus.out_rob[5:0] !== 6'd3) $display("FAIL rst_ch2_rob: got %0d want 3", bus.out_rob[5:0]);
        else n_pass++;
        n_checks++;
        if (bus.out_regwrite[0] !== 1'b1) $display("FAIL rst_ch2_rw: got %b want 1", bus.out_regwrite[0]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int a;
        int e;
        do_reset();
        wb_stall = 1'b1;
        for (int ent = 0; ent < 2; ent++) begin
            for (int c = 0; c < NUM_CH; c++)
                set_ch(c, 32'h100*c + ent, 6'(c*8 + ent), 6'(c*2 + ent), c[0]);
            bus.in_valid = 4'hF;
            @(negedge clk);
        end
        bus.in_valid = '0;
        wb_stall = 1'b0;
        for (int step = 0; step < 4; step++) begin
            @(negedge clk);
            a = (step % 2) * 2;
            e = step / 2;
            n_checks++;
            if (bus.out_valid !== 2'b11) $display("FAIL rr_vld_s%0d: got %b want 11", step, bus.out_valid);
            else n_pass++;
            n_checks++;
            if (lane_dat(0) !== 32'(32'h100*a + e))
                $display("FAIL rr_lane0_s%0d: got %h want %h", step, lane_dat(0), 32'h100*a + e);
            else n_pass++;
            n_checks++;
            if (lane_dat(1) !== 32'(32'h100*(a+1) + e))
                $display("FAIL rr_lane1_s%0d: got %h want %h", step, lane_dat(1), 32'h100*(a+1) + e);
            else n_pass++;
            n_checks++;
            if (lane_preg(1) !== 6'((a+1)*8 + e))
                $display("FAIL rr_preg1_s%0d: got %0d want %0d", step, lane_preg(1), (a+1)*8 + e);
            else n_pass++;
            n_checks++;
            if (bus.out_regwrite !== 2'b10)
                $display("FAIL rr_rw_s%0d: got %b want 10", step, bus.out_regwrite);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 2'b00) $display("FAIL rr_empty: got %b want 00", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [31:0] got[$];
        logic        last_acc;
        int          lane1_seen;
        do_reset();
        wb_stall = 1'b1;
        bus.in_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 32'hD000_0000 + k, 6'(k), 6'(k), 1'b1);
            @(negedge clk);
            if (k == 2) begin
                n_checks++;
                if (bus.in_ready[0] !== 1'b1) $display("FAIL bp_ready_after3: got %b want 1", bus.in_ready[0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (bus.in_ready[0] !== 1'b0) $display("FAIL bp_ready_after4: got %b want 0", bus.in_ready[0]);
        else n_pass++;
        set_ch(0, 32'hD000_0004, 6'd4, 6'd4, 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 4'b1110) $display("FAIL bp_fifth_held: got %b want 1110", bus.in_ready);
        else n_pass++;
        wb_stall = 1'b0;
        last_acc = 1'b0;
        lane1_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (last_acc) bus.in_valid[0] = 1'b0;
            if (bus.out_valid[0] === 1'b1) got.push_back(lane_dat(0));
            if (bus.out_valid[1] === 1'b1) lane1_seen++;
            last_acc = bus.in_valid[0] && bus.in_ready[0];
        end
        n_checks++;
        if (got.size() != 5) $display("FAIL bp_count: got %0d want 5", got.size());
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= got.size()) $display("FAIL bp_order_%0d: got missing want %h", k, 32'hD000_0000 + k);
            else if (got[k] !== 32'(32'hD000_0000 + k))
                $display("FAIL bp_order_%0d: got %h want %h", k, got[k], 32'hD000_0000 + k);
            else n_pass++;
        end
        n_checks++;
        if (lane1_seen != 0) $display("FAIL bp_lane1_idle: got %0d want 0", lane1_seen);
        else n_pass++;
    endtask

    task automatic test_stall_hold();
        do_reset();
        wb_stall = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'h400 + c, 6'(c), 6'(c), 1'b1);
        bus.in_valid = 4'hF;
        @(negedge clk);
        bus.in_valid = '0;
        wb_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, lane_dat(0), lane_dat(1)} !== {2'b11, 32'h400, 32'h401})
            $display("FAIL stall_pre: got %b %h %h want 11 400 401", bus.out_valid, lane_dat(0), lane_dat(1));
        else n_pass++;
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid, lane_dat(0), lane_dat(1)} !== {2'b11, 32'h400, 32'h401})
                $display("FAIL stall_hold_%0d: got %b %h %h want 11 400 401", i, bus.out_valid, lane_dat(0), lane_dat(1));
            else n_pass++;
        end
        wb_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, lane_dat(0), lane_dat(1)} !== {2'b11, 32'h402, 32'h403})
            $display("FAIL stall_resume: got %b %h %h want 11 402 403", bus.out_valid, lane_dat(0), lane_dat(1));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 2'b00) $display("FAIL stall_no_dup: got %b want 00", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        wb_stall = 1'b1;
        for (int c = 0; c < 3; c++) set_ch(c, 32'h500 + c, 6'(c), 6'(c), 1'b1);
        bus.in_valid = 4'b0111;
        @(negedge clk);
        set_ch(0, 32'h510, 6'd10, 6'd10, 1'b1);
        bus.in_valid = 4'b0001;
        @(negedge clk);
        bus.in_valid = '0;
        wb_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 2'b11) $display("FAIL flush_pre: got %b want 11", bus.out_valid);
        else n_pass++;
        flush = 1'b1;
        set_ch(1, 32'hDEAD, 6'd33, 6'd33, 1'b1);
        bus.in_valid = 4'b0010;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = '0;
        n_checks++;
        if (bus.out_valid !== 2'b00) $display("FAIL flush_out_valid: got %b want 00", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 4'hF) $display("FAIL flush_in_ready: got %h want f", bus.in_ready);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 2'b00) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL flush_nothing_after: got %0d valid cycles want 0", seen);
        else n_pass++;
    endtask

`ifdef WB_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        wb_stall = 1'b1;
        set_ch(3, 32'h600, 6'd3, 6'd3, 1'b1);
        bus.in_valid = 4'b1000;
        repeat (14) @(negedge clk);
        bus.in_valid = '0;
        n_checks++;
        if (perf_bp_cycles !== 32'd10) $display("FAIL perf_count: got %0d want 10", perf_bp_cycles);
        else n_pass++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (perf_bp_cycles !== 32'd0) $display("FAIL perf_flush: got %0d want 0", perf_bp_cycles);
        else n_pass++;
    endtask
`endif

    initial begin
        reset_n = 1'b1;
        flush = 1'b0;
        wb_stall = 1'b0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.in_preg = '0;
        bus.in_rob = '0;
        bus.in_regwrite = '0;
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_stall_hold();
        test_flush();
`ifdef WB_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
